// File: rtl/cordic_controller_if.sv
// Request, angle-scaler, iteration-datapath and result signals of the CORDIC controller.
// master = controller side, slave = surrounding datapath/environment side.
interface cordic_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_angle;
    logic                  in_ready;

    logic                  scaler_clk_en;
    logic [DATA_WIDTH-1:0] scaler_angle;
    logic [DATA_WIDTH-1:0] scaler_scaled;
    logic                  scaler_sign;
    logic                  scaler_done;

    logic                  iter_load;
    logic [DATA_WIDTH-1:0] iter_angle;
    logic                  iter_en;
    logic [5:0]            iter_index;
    logic [DATA_WIDTH-1:0] iter_x;
    logic [DATA_WIDTH-1:0] iter_y;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_cos;
    logic [DATA_WIDTH-1:0] out_sin;
    logic                  out_error;
    logic                  busy;

    modport master (
        input  in_valid, in_angle, scaler_scaled, scaler_sign, scaler_done,
               iter_x, iter_y, out_ready,
        output in_ready, scaler_clk_en, scaler_angle, iter_load, iter_angle,
               iter_en, iter_index, out_valid, out_cos, out_sin, out_error, busy
    );

    modport slave (
        output in_valid, in_angle, scaler_scaled, scaler_sign, scaler_done,
               iter_x, iter_y, out_ready,
        input  in_ready, scaler_clk_en, scaler_angle, iter_load, iter_angle,
               iter_en, iter_index, out_valid, out_cos, out_sin, out_error, busy
    );
endinterface

// File: rtl/cordic_controller.sv
// CORDIC sequencer: scale -> load -> ITERATIONS micro-rotations -> capture; ITERATIONS+3 edges accept-to-valid.
// One request in flight; in_ready only in IDLE, result held until out_ready; scaler stall bounded by SCALE_TIMEOUT.
module cordic_controller #(
    parameter int DATA_WIDTH    = 32,
    parameter int ITERATIONS    = 16,
    parameter int SCALE_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    cordic_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_LOAD,
        S_ITERATE,
        S_CAPTURE,
        S_OUT
    } state_t;

    localparam int             TW       = $clog2(SCALE_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(SCALE_TIMEOUT - 1);
    localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
    localparam logic [5:0]     IDX_LAST = 6'(ITERATIONS - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] angle_q, angle_d;
    logic [DATA_WIDTH-1:0] scaled_q, scaled_d;
    logic                  sign_q, sign_d;
    logic [5:0]            idx_q, idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] cos_q, cos_d;
    logic [DATA_WIDTH-1:0] sin_q, sin_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            angle_q  <= '0;
            scaled_q <= '0;
            sign_q   <= 1'b1;
            idx_q    <= '0;
            tmo_q    <= '0;
            cos_q    <= '0;
            sin_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            angle_q  <= angle_d;
            scaled_q <= scaled_d;
            sign_q   <= sign_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            cos_q    <= cos_d;
            sin_q    <= sin_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        angle_d  = angle_q;
        scaled_d = scaled_q;
        sign_d   = sign_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        cos_d    = cos_q;
        sin_d    = sin_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    angle_d = bus.in_angle;
                    tmo_d   = '0;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                // A done arriving on the final allowed cycle still counts as success.
                if (bus.scaler_done) begin
                    scaled_d = bus.scaler_scaled;
                    sign_d   = bus.scaler_sign;
                    idx_d    = '0;
                    state_d  = S_LOAD;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    cos_d   = '0;
                    sin_d   = '0;
                    state_d = S_OUT;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_ITERATE;
            end
            S_ITERATE: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_CAPTURE: begin
                // Negative sign from the scaler folds the angle into the opposite half-plane.
                cos_d   = sign_q ? bus.iter_x : -bus.iter_x;
                sin_d   = sign_q ? bus.iter_y : -bus.iter_y;
                err_d   = 1'b0;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready      = (state_q == S_IDLE) && !rst;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.scaler_clk_en = (state_q == S_SCALE);
    assign bus.scaler_angle  = angle_q;
    assign bus.iter_load     = (state_q == S_LOAD);
    assign bus.iter_angle    = scaled_q;
    assign bus.iter_en       = (state_q == S_ITERATE);
    assign bus.iter_index    = idx_q;
    assign bus.out_valid     = (state_q == S_OUT);
    assign bus.out_cos       = cos_q;
    assign bus.out_sin       = sin_q;
    assign bus.out_error     = err_q;
endmodule

// File: tb/tb_cordic_controller.sv
// Directed bench for cordic_controller: driver pushes expected results, monitors compare on out_valid.
module tb_cordic_controller;
    localparam int DW   = 32;
    localparam int ITER = 16;
    localparam int TMO  = 64;

    typedef struct {
        logic [31:0] cos;
        logic [31:0] sin;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_controller_if #(.DATA_WIDTH(DW)) bus ();

    cordic_controller #(
        .DATA_WIDTH   (DW),
        .ITERATIONS   (ITER),
        .SCALE_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          scale_cnt = 0;
    logic        done_en = 1'b0;
    int          done_at = 0;
    logic        sign_drv = 1'b1;
    logic [31:0] cur_angle = '0;
    exp_t        exp_q[$];

    // Scaler model: done after done_at SCALE cycles, scaled value is a fixed XOR of the angle.
    assign bus.scaler_done   = bus.scaler_clk_en & done_en & (scale_cnt == done_at);
    assign bus.scaler_scaled = bus.scaler_angle ^ 32'h5A5A_0000;
    assign bus.scaler_sign   = sign_drv;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        scale_cnt <= bus.scaler_clk_en ? scale_cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Iteration monitor: index sequence, run length, load angle.
    int   exp_idx = 0;
    int   load_cnt = 0;
    int   en_cnt = 0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_idx = 0;
            prev_en = 1'b0;
        end else begin
            if (bus.iter_load) begin
                load_cnt++;
                chk("load_index", 64'(bus.iter_index), 64'd0);
                chk("iter_angle", 64'(bus.iter_angle), 64'(cur_angle ^ 32'h5A5A_0000));
                exp_idx = 0;
            end
            if (bus.iter_en) begin
                en_cnt++;
                chk("iter_index", 64'(bus.iter_index), 64'(exp_idx));
                exp_idx++;
            end else if (prev_en) begin
                chk("iter_run_len", 64'(exp_idx), 64'(ITER));
            end
            prev_en = bus.iter_en;
        end
    end

    // Result monitor: pops on each new out_valid, checks every held cycle.
    exp_t cur_e;
    logic prev_vld = 1'b0;
    int   completions = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (!prev_vld) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_completion: out_valid=1 required none pending");
                        cur_e = '{cos: 32'h0, sin: 32'h0, err: 1'b0, lat: 0, acc: 0};
                    end else begin
                        cur_e = exp_q.pop_front();
                        chk("latency", 64'(cyc - cur_e.acc), 64'(cur_e.lat));
                    end
                    completions++;
                end
                chk("out_cos", 64'(bus.out_cos), 64'(cur_e.cos));
                chk("out_sin", 64'(bus.out_sin), 64'(cur_e.sin));
                chk("out_error", 64'(bus.out_error), 64'(cur_e.err));
                chk("in_ready_in_out", 64'(bus.in_ready), 64'd0);
            end
            prev_vld = bus.out_valid;
        end
    end

    // Called at a falling edge; queues the expected result once the request will be accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] c, input logic [31:0] s,
                        input logic e, input int lat);
        int   guard = 0;
        exp_t x;
        bus.in_valid = 1'b1;
        bus.in_angle = a;
        while (!bus.in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 required 1 within 500 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        x.cos = c;
        x.sin = s;
        x.err = e;
        x.lat = lat;
        x.acc = cyc + 1;
        exp_q.push_back(x);
        cur_angle = a;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_comp(input int n);
        int g = 0;
        while (completions < n && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) begin
            vectors++;
            errors++;
            $display("FAIL completion_timeout: got %0d completions required %0d", completions, n);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int l0;
        int e0;
        int g;

        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;
        bus.iter_x    = '0;
        bus.iter_y    = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_iter_index", 64'(bus.iter_index), 64'd0);
        chk("rst_strobes", 64'({bus.scaler_clk_en, bus.iter_load, bus.iter_en}), 64'd0);
        chk("rst_results", 64'({bus.out_cos, bus.out_error}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Positive sign, immediate done.
        done_en = 1'b1; done_at = 0; sign_drv = 1'b1; bus.out_ready = 1'b1;
        bus.iter_x = 32'h1234_5678; bus.iter_y = 32'h0000_ABCD;
        send(32'h2000_0000, 32'h1234_5678, 32'h0000_ABCD, 1'b0, ITER + 3);
        chk("scale_angle", 64'(bus.scaler_angle), 64'h2000_0000);
        chk("scale_en", 64'({bus.scaler_clk_en, bus.busy, bus.in_ready}), 64'b110);
        wait_comp(1);

        // Negative sign: results negated, most-negative value wraps to itself.
        sign_drv = 1'b0;
        send(32'h2000_0000, 32'hEDCB_A988, 32'hFFFF_5433, 1'b0, ITER + 3);
        wait_comp(2);
        bus.iter_x = 32'h8000_0000; bus.iter_y = 32'h0000_0001;
        send(32'h1111_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, ITER + 3);
        wait_comp(3);

        // Scaler never finishes: error completion, datapath untouched.
        done_en = 1'b0; l0 = load_cnt; e0 = en_cnt;
        send(32'h0F0F_0F0F, 32'h0, 32'h0, 1'b1, TMO);
        wait_comp(4);
        chk("tmo_no_load", 64'(load_cnt - l0), 64'd0);
        chk("tmo_no_iter", 64'(en_cnt - e0), 64'd0);

        // Done on the very cycle the timeout expires: done wins.
        done_en = 1'b1; done_at = TMO - 1; sign_drv = 1'b1;
        bus.iter_x = 32'h0000_0042; bus.iter_y = 32'hC000_0000;
        send(32'h3333_4444, 32'h0000_0042, 32'hC000_0000, 1'b0, TMO - 1 + ITER + 3);
        wait_comp(5);
        done_at = 0;

        // Backpressure with a competing request held on the input.
        bus.out_ready = 1'b0; c0 = completions;
        send(32'h0000_1000, 32'h0000_0042, 32'hC000_0000, 1'b0, ITER + 3);
        g = 0;
        while (!bus.out_valid && g < 100) begin @(negedge clk); g++; end
        bus.in_valid = 1'b1; bus.in_angle = 32'hDEAD_BEEF;
        repeat (10) @(negedge clk);
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_release", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
        repeat (5) @(negedge clk);
        chk("bp_one_completion", 64'(completions - c0), 64'd1);

        // Reset in the middle of ITERATE.
        c0 = completions;
        send(32'h2000_0000, 32'h0, 32'h0, 1'b0, ITER + 3);
        g = 0;
        while (!(bus.iter_en && bus.iter_index == 6'd7) && g < 100) begin @(negedge clk); g++; end
        chk("mid_iter_reached", 64'(bus.iter_index), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", 64'({bus.iter_en, bus.out_valid, bus.busy, bus.in_ready}), 64'd0);
        chk("abort_index", 64'(bus.iter_index), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (30) @(negedge clk);
        chk("abort_no_output", 64'(completions - c0), 64'd0);

        // Back-to-back requests.
        c0 = completions; l0 = load_cnt;
        bus.iter_x = 32'h0000_0010; bus.iter_y = 32'hFFFF_FFF0; sign_drv = 1'b1;
        send(32'h0000_0001, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0, ITER + 3);
        send(32'h0000_0002, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0, ITER + 3);
        send(32'h0000_0003, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0, ITER + 3);
        wait_comp(c0 + 3);
        chk("b2b_loads", 64'(load_cnt - l0), 64'd3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cordic_controller.md
CORDIC_CONTROLLER -- requirements
Module: cordic_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of angle and result words.
REQ-002 Parameter ITERATIONS, default 16, number of CORDIC micro-rotations per request (2..64).
REQ-003 Parameter SCALE_TIMEOUT, default 64, maximum cycles spent waiting for scaler done.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  request present; in_angle  input  DATA_WIDTH  request angle.
REQ-007 in_ready  output  1  controller can accept a request.
REQ-008 scaler_clk_en  output  1  enable to angle scaler; scaler_angle  output  DATA_WIDTH  latched request angle.
REQ-009 scaler_scaled  input  DATA_WIDTH; scaler_sign  input  1; scaler_done  input  1  angle scaler results.
REQ-010 iter_load  output  1  load iteration datapath with iter_angle; iter_angle  output  DATA_WIDTH  latched scaled angle.
REQ-011 iter_en  output  1  perform one micro-rotation; iter_index  output  6  current iteration number.
REQ-012 iter_x, iter_y  input  DATA_WIDTH each  datapath cosine/sine accumulators.
REQ-013 out_valid  output  1; out_ready  input  1; out_cos, out_sin  output  DATA_WIDTH each; out_error  output  1.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SCALE, LOAD, ITERATE, CAPTURE, OUT.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready latch in_angle into scaler_angle, clear timeout counter, go SCALE.
REQ-017 SCALE: scaler_clk_en=1 every cycle; on scaler_done=1 latch scaler_scaled into iter_angle and scaler_sign into sign register, go LOAD.
REQ-018 SCALE: timeout counter increments each cycle without done; when it reaches SCALE_TIMEOUT-1 without done, go OUT with out_error=1, out_cos=out_sin=0.
REQ-019 scaler_done and timeout on the same cycle: done SHALL win (no error).
REQ-020 LOAD: iter_load=1 for exactly one cycle, iter_index=0, then go ITERATE.
REQ-021 ITERATE: iter_en=1 for exactly ITERATIONS consecutive cycles, iter_index=0..ITERATIONS-1 incrementing by one per cycle; after index ITERATIONS-1 go CAPTURE.
REQ-022 CAPTURE: sample iter_x, iter_y; if sign=1 out_cos=iter_x, out_sin=iter_y; if sign=0 both two's-complement negated (width DATA_WIDTH, wrap on most-negative value); out_error=0; go OUT.
REQ-023 OUT: out_valid=1, outputs held stable until out_valid&out_ready; then go IDLE, out_valid=0 next cycle.
REQ-024 in_ready SHALL be 0 in all states except IDLE; new requests are never accepted while out_valid=1.
REQ-025 iter_load, iter_en, scaler_clk_en SHALL be 0 outside their stated states.
REQ-026 Latency: with scaler_done high in first SCALE cycle, out_valid SHALL rise ITERATIONS+3 clock edges after the accepting edge (19 for default).
REQ-027 out_ready ignored when out_valid=0.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE from any state, including mid-ITERATE or OUT, discarding the request.
REQ-029 Reset values: in_ready=0 during reset then 1 in IDLE, all other outputs 0, iter_index=0, counters 0, sign register 1.

Verification
REQ-030 Angle 0x20000000, scaler_done immediate, sign=1, iter_x=0x12345678, iter_y=0x0000ABCD at CAPTURE, out_ready=1 -> out_valid 19 edges after accept, out_cos=0x12345678, out_sin=0x0000ABCD, out_error=0.
REQ-031 Same with sign=0 -> out_cos=0xEDCBA988, out_sin=0xFFFF5433; iter_x=0x80000000 -> out_cos=0x80000000.
REQ-032 scaler_done never asserted -> after 64 SCALE cycles out_valid=1, out_error=1, results 0; iter_load/iter_en never pulsed.
REQ-033 out_ready held 0 for 10 cycles in OUT, in_valid held 1 -> outputs stable, in_ready=0, one completion only; IDLE one edge after out_ready=1.
REQ-034 rst asserted at iter_index=7 -> next cycle IDLE, iter_en=0, out_valid=0, in_ready=1 after rst drops.
REQ-035 Back-to-back requests with out_ready=1 -> iter_load count equals accepted requests, iter_index sequence 0..15 each time.
